// File: rtl/filter_spad_seq.sv
// Filter scratchpad sequencer: loads a weight stream into the scratchpad, then
// replays it to the PE MAC in address order for a configurable number of passes.
module filter_spad_seq #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              skip_load,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [7:0]        cfg_reps,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              spad_wr,
    output logic              spad_rd,
    output logic [ADDR_W-1:0] spad_addr,
    output logic [DATA_W-1:0] spad_wdata,
    input  logic [DATA_W-1:0] spad_rdata,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last,
    input  logic              w_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] rcnt;
    logic [7:0]        reps;
    logic [7:0]        pcnt;
    logic              w_valid_q;
    logic              w_last_q;
    logic              cfg_err_q;

    logic [ADDR_W:0]   len_m1;
    logic              cfg_bad;
    logic              accept;
    logic              wr_hs;
    logic              wr_last;
    logic              reads_left;
    logic              rd_go;
    logic              rd_wrap;
    logic              final_hs;

    assign len_m1     = cfg_len - (ADDR_W+1)'(1);
    assign cfg_bad    = (cfg_len == '0) || (cfg_len > (ADDR_W+1)'(DEPTH));
    assign accept     = (state == S_IDLE) && start && !cfg_bad;
    assign wr_hs      = (state == S_LOAD) && in_valid;
    assign wr_last    = wr_hs && (wcnt == last_idx);
    assign reads_left = (pcnt != reps);
    assign rd_go      = (state == S_STREAM) && (!w_valid_q || w_ready) && reads_left;
    assign rd_wrap    = (rcnt == last_idx);
    // Once every read is issued, the beat on the bus is the final one of the command.
    assign final_hs   = (state == S_STREAM) && w_valid_q && w_ready && !reads_left;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!skip_load)
                        state_nxt = S_LOAD;
                    else if (cfg_reps == 8'd0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_STREAM;
                end
            end
            S_LOAD: begin
                if (wr_last)
                    state_nxt = (reps != 8'd0) ? S_STREAM : S_DONE;
            end
            S_STREAM: begin
                if (final_hs)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready   = (state == S_LOAD);
        spad_wr    = wr_hs;
        spad_rd    = rd_go;
        spad_addr  = '0;
        spad_wdata = '0;
        if (wr_hs) begin
            spad_addr  = wcnt;
            spad_wdata = in_data;
        end else if (rd_go) begin
            spad_addr  = rcnt;
        end
        w_valid    = w_valid_q;
        w_data     = w_valid_q ? spad_rdata : '0;
        w_last     = w_last_q;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        cfg_err    = cfg_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_idx  <= '0;
            reps      <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            pcnt      <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state == S_IDLE) && start && cfg_bad;

            if (accept) begin
                last_idx <= len_m1[ADDR_W-1:0];
                reps     <= cfg_reps;
            end

            if (state == S_LOAD) begin
                if (wr_hs)
                    wcnt <= wr_last ? '0 : wcnt + ADDR_W'(1);
            end else begin
                wcnt <= '0;
            end

            // Scratchpad data_out holds between reads, so a stalled beat needs no skid register.
            if (state == S_STREAM) begin
                if (rd_go) begin
                    rcnt      <= rd_wrap ? '0 : rcnt + ADDR_W'(1);
                    if (rd_wrap)
                        pcnt  <= pcnt + 8'd1;
                    w_valid_q <= 1'b1;
                    w_last_q  <= rd_wrap;
                end else if (w_ready) begin
                    w_valid_q <= 1'b0;
                    w_last_q  <= 1'b0;
                end
            end else begin
                rcnt      <= '0;
                pcnt      <= '0;
                w_valid_q <= 1'b0;
                w_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_spad_seq.sv
// Bench for filter_spad_seq: scratchpad model, randomized upstream/MAC handshakes,
// and an expected-stream model built from what the bench itself loaded.
module tb_filter_spad_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       skip_load;
    logic [6:0] cfg_len;
    logic [7:0] cfg_reps;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       spad_wr;
    logic       spad_rd;
    logic [5:0] spad_addr;
    logic [7:0] spad_wdata;
    logic [7:0] spad_rdata;
    logic       w_valid;
    logic [7:0] w_data;
    logic       w_last;
    logic       w_ready;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] spad_mem [64];
    int ref_mem [64];
    int src [64];

    int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
    int beat_data_q[$], beat_last_q[$], beat_cyc_q[$];
    int exp_data_q[$], exp_last_q[$];
    int rd_cnt, err_cnt, viol_cnt, stall_cycles, stall_rd, stall_bad, done_cyc;
    int post_busy, post_done;
    bit timed_out;

    filter_spad_seq #(.ADDR_W(6), .DATA_W(8), .DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .skip_load  (skip_load),
        .cfg_len    (cfg_len),
        .cfg_reps   (cfg_reps),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .spad_wr    (spad_wr),
        .spad_rd    (spad_rd),
        .spad_addr  (spad_addr),
        .spad_wdata (spad_wdata),
        .spad_rdata (spad_rdata),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_last     (w_last),
        .w_ready    (w_ready),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Scratchpad with registered read data that holds when not reading.
    always @(posedge clk) begin
        if (spad_wr) spad_mem[spad_addr] <= spad_wdata;
        if (spad_rd) spad_rdata <= spad_mem[spad_addr];
    end

    // Expected beat stream: reps passes over the stored weights, last flag on each pass end.
    function automatic void build_expect(input int len, input int reps);
        exp_data_q.delete();
        exp_last_q.delete();
        for (int p = 0; p < reps; p++)
            for (int a = 0; a < len; a++) begin
                exp_data_q.push_back(ref_mem[a]);
                exp_last_q.push_back(a == len - 1);
            end
    endfunction

    task automatic run_cmd(input int len, input int reps, input bit skip,
                           input int vprob, input int rprob, input int stall_val, input bit poke);
        int idx;
        int stall_left;
        bit stalling;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
        rd_cnt = 0; err_cnt = 0; viol_cnt = 0;
        stall_cycles = 0; stall_rd = 0; stall_bad = 0;
        done_cyc = -1; timed_out = 1'b1;
        idx = 0;
        stall_left = (stall_val >= 0) ? 3 : 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0) || (poke && cyc == 2);
            skip_load = (cyc == 0) ? skip : 1'b1;
            cfg_len   = (cyc == 0) ? 7'(len) : 7'd0;
            cfg_reps  = 8'(reps);
            if (!skip && idx < len) begin
                in_valid = ($urandom_range(99) < vprob);
                in_data  = 8'(src[idx]);
            end else begin
                in_valid = 1'($urandom_range(1));
                in_data  = 8'($urandom);
            end
            stalling = (stall_left > 0) && (stall_left < 3 || (w_valid && w_data == 8'(stall_val)));
            if (stalling) begin
                stall_left--;
                w_ready = 1'b0;
            end else begin
                w_ready = ($urandom_range(99) < rprob);
            end
            #1;
            if (stalling) begin
                stall_cycles++;
                if (spad_rd) stall_rd++;
                if (w_data != 8'(stall_val)) stall_bad++;
            end
            if (in_valid && in_ready) idx++;
            if (spad_wr) begin
                wr_addr_q.push_back(int'(spad_addr));
                wr_data_q.push_back(int'(spad_wdata));
                wr_cyc_q.push_back(cyc);
                if (!(in_valid && in_ready)) viol_cnt++;
            end
            if (spad_rd) rd_cnt++;
            if (spad_rd && spad_wr) viol_cnt++;
            if ((spad_rd || spad_wr) && int'(spad_addr) >= len) viol_cnt++;
            if (w_valid && w_ready) begin
                beat_data_q.push_back(int'(w_data));
                beat_last_q.push_back(int'(w_last));
                beat_cyc_q.push_back(cyc);
            end
            if (cfg_err) err_cnt++;
            if (done) begin
                done_cyc = cyc;
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; w_ready = 1'b1;
        #1;
        post_busy = int'(busy);
        post_done = int'(done);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; skip_load = 1'b0; cfg_len = '0; cfg_reps = '0;
        in_valid = 1'b0; in_data = '0; w_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, spad_wr, spad_rd, spad_addr, spad_wdata, w_valid, w_data, w_last, busy, done, cfg_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {in_ready, spad_wr, spad_rd, spad_addr, spad_wdata, w_valid, w_data, w_last, busy, done, cfg_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({in_ready, spad_wr, spad_rd, spad_addr, w_valid, w_last, busy, done, cfg_err} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: got %h required 0", {in_ready, spad_wr, spad_rd, spad_addr, w_valid, w_last, busy, done, cfg_err});
        end
    endtask

    task automatic test_load_stream();
        src[0] = 'h11; src[1] = 'h22; src[2] = 'h33; src[3] = 'h44;
        run_cmd(4, 2, 1'b0, 100, 100, -1, 1'b0);
        for (int i = 0; i < 4; i++) ref_mem[i] = src[i];
        build_expect(4, 2);
        checks++;
        if (timed_out) begin failures++; $display("FAIL ls_timeout: no done within budget"); end
        checks++;
        if (wr_addr_q.size() != 4) begin failures++; $display("FAIL ls_write_count: got %0d required 4", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            checks++;
            if (wr_addr_q[i] != i || wr_data_q[i] != src[i] || wr_cyc_q[i] != i + 1) begin
                failures++;
                $display("FAIL ls_write[%0d]: got addr %0d data %h cyc %0d required addr %0d data %h cyc %0d",
                         i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], i, src[i], i + 1);
            end
        end
        checks++;
        if (beat_data_q.size() != 8) begin failures++; $display("FAIL ls_beat_count: got %0d required 8", beat_data_q.size()); end
        for (int i = 0; i < beat_data_q.size() && i < 8; i++) begin
            checks++;
            if (beat_data_q[i] != exp_data_q[i] || beat_last_q[i] != exp_last_q[i] || beat_cyc_q[i] != 6 + i) begin
                failures++;
                $display("FAIL ls_beat[%0d]: got data %h last %0d cyc %0d required data %h last %0d cyc %0d",
                         i, beat_data_q[i], beat_last_q[i], beat_cyc_q[i], exp_data_q[i], exp_last_q[i], 6 + i);
            end
        end
        checks++;
        if (done_cyc != 14 || post_done != 0 || post_busy != 0) begin
            failures++;
            $display("FAIL ls_done: got cyc %0d next done %0d busy %0d required cyc 14 then 0 0", done_cyc, post_done, post_busy);
        end
        checks++;
        if (viol_cnt != 0) begin failures++; $display("FAIL ls_protocol: got %0d violations required 0", viol_cnt); end
    endtask

    task automatic test_backpressure();
        run_cmd(4, 2, 1'b0, 100, 100, 'h22, 1'b0);
        build_expect(4, 2);
        checks++;
        if (beat_data_q.size() != exp_data_q.size()) begin
            failures++; $display("FAIL bp_beat_count: got %0d required %0d", beat_data_q.size(), exp_data_q.size());
        end
        for (int i = 0; i < beat_data_q.size() && i < exp_data_q.size(); i++) begin
            checks++;
            if (beat_data_q[i] != exp_data_q[i] || beat_last_q[i] != exp_last_q[i]) begin
                failures++;
                $display("FAIL bp_beat[%0d]: got %h/%0d required %h/%0d", i, beat_data_q[i], beat_last_q[i], exp_data_q[i], exp_last_q[i]);
            end
        end
        checks++;
        if (stall_cycles != 3 || stall_rd != 0 || stall_bad != 0) begin
            failures++;
            $display("FAIL bp_stall: got cycles %0d reads %0d data_moves %0d required 3 0 0", stall_cycles, stall_rd, stall_bad);
        end
        checks++;
        if (timed_out || beat_cyc_q.size() == 0 || done_cyc != beat_cyc_q[beat_cyc_q.size() - 1] + 1) begin
            failures++; $display("FAIL bp_done: got done cyc %0d timeout %0d", done_cyc, timed_out);
        end
    endtask

    task automatic test_cfg_err();
        int bad_lens [3];
        int first_err, extra_err, busy_seen, strobes;
        bad_lens[0] = 0; bad_lens[1] = 65; bad_lens[2] = 127;
        foreach (bad_lens[k]) begin
            @(negedge clk);
            start = 1'b1; skip_load = 1'b0; cfg_len = 7'(bad_lens[k]); cfg_reps = 8'd1;
            in_valid = 1'b1; in_data = 8'($urandom); w_ready = 1'b1;
            #1;
            extra_err = int'(cfg_err);
            busy_seen = int'(busy);
            strobes = int'(spad_wr | spad_rd);
            @(negedge clk);
            start = 1'b0;
            #1;
            first_err = int'(cfg_err);
            busy_seen += int'(busy);
            strobes += int'(spad_wr | spad_rd);
            repeat (3) begin
                @(negedge clk);
                #1;
                extra_err += int'(cfg_err);
                busy_seen += int'(busy);
                strobes += int'(spad_wr | spad_rd);
            end
            checks++;
            if (first_err != 1 || extra_err != 0) begin
                failures++;
                $display("FAIL cfg_err_pulse len=%0d: got next %0d other %0d required 1 0", bad_lens[k], first_err, extra_err);
            end
            checks++;
            if (busy_seen != 0 || strobes != 0) begin
                failures++;
                $display("FAIL cfg_err_idle len=%0d: got busy %0d strobes %0d required 0 0", bad_lens[k], busy_seen, strobes);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reuse();
        run_cmd(4, 1, 1'b1, 100, 100, -1, 1'b0);
        build_expect(4, 1);
        checks++;
        if (wr_addr_q.size() != 0) begin failures++; $display("FAIL reuse_writes: got %0d required 0", wr_addr_q.size()); end
        checks++;
        if (beat_data_q.size() != 4) begin failures++; $display("FAIL reuse_beat_count: got %0d required 4", beat_data_q.size()); end
        for (int i = 0; i < beat_data_q.size() && i < 4; i++) begin
            checks++;
            if (beat_data_q[i] != exp_data_q[i] || beat_last_q[i] != exp_last_q[i] || beat_cyc_q[i] != 2 + i) begin
                failures++;
                $display("FAIL reuse_beat[%0d]: got %h/%0d cyc %0d required %h/%0d cyc %0d", i, beat_data_q[i], beat_last_q[i],
                         beat_cyc_q[i], exp_data_q[i], exp_last_q[i], 2 + i);
            end
        end
        run_cmd(4, 0, 1'b1, 100, 100, -1, 1'b0);
        checks++;
        if (done_cyc != 1 || rd_cnt != 0 || beat_data_q.size() != 0 || wr_addr_q.size() != 0) begin
            failures++;
            $display("FAIL reuse_zero_reps: got done cyc %0d reads %0d beats %0d writes %0d required 1 0 0 0",
                     done_cyc, rd_cnt, beat_data_q.size(), wr_addr_q.size());
        end
    endtask

    task automatic test_full_depth();
        int bad;
        for (int i = 0; i < 64; i++) src[i] = int'($urandom_range(255));
        run_cmd(64, 2, 1'b0, 50, 100, -1, 1'b0);
        for (int i = 0; i < 64; i++) ref_mem[i] = src[i];
        build_expect(64, 2);
        checks++;
        if (wr_addr_q.size() != 64 || viol_cnt != 0) begin
            failures++; $display("FAIL full_writes: got %0d writes %0d violations required 64 0", wr_addr_q.size(), viol_cnt);
        end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 64; i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != src[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL full_write_order: got %0d wrong writes required 0", bad); end
        checks++;
        if (beat_data_q.size() != 128) begin failures++; $display("FAIL full_beat_count: got %0d required 128", beat_data_q.size()); end
        bad = 0;
        for (int i = 0; i < beat_data_q.size() && i < 128; i++)
            if (beat_data_q[i] != exp_data_q[i] || beat_last_q[i] != exp_last_q[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL full_beats: got %0d wrong beats required 0", bad); end
        checks++;
        if (beat_data_q.size() == 0 || beat_data_q[beat_data_q.size() - 1] != src[63] || timed_out) begin
            failures++; $display("FAIL full_last_beat: size %0d timeout %0d required last %h", beat_data_q.size(), timed_out, src[63]);
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 8; i++) src[i] = int'($urandom_range(255));
        run_cmd(8, 1, 1'b0, 100, 100, -1, 1'b1);
        for (int i = 0; i < 8; i++) ref_mem[i] = src[i];
        build_expect(8, 1);
        checks++;
        if (err_cnt != 0 || wr_addr_q.size() != 8 || timed_out) begin
            failures++; $display("FAIL poke_start: got err %0d writes %0d timeout %0d required 0 8 0", err_cnt, wr_addr_q.size(), timed_out);
        end
        checks++;
        if (beat_data_q != exp_data_q) begin
            failures++; $display("FAIL poke_beats: got %0d beats, sequence differs from the 8 loaded weights", beat_data_q.size());
        end
    endtask

    task automatic test_random();
        int len, reps, bad;
        bit skip;
        for (int it = 0; it < 8; it++) begin
            len  = (it == 0) ? 1 : int'($urandom_range(64, 1));
            reps = (it == 0) ? 3 : int'($urandom_range(3));
            skip = (it > 0) && ($urandom_range(1) == 1);
            if (!skip) for (int i = 0; i < len; i++) src[i] = int'($urandom_range(255));
            run_cmd(len, reps, skip, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), -1, 1'b0);
            if (!skip) for (int i = 0; i < len; i++) ref_mem[i] = src[i];
            build_expect(len, reps);
            bad = 0;
            for (int i = 0; i < beat_data_q.size() && i < exp_data_q.size(); i++)
                if (beat_data_q[i] != exp_data_q[i] || beat_last_q[i] != exp_last_q[i]) bad++;
            checks++;
            if (timed_out || bad != 0 || beat_data_q.size() != exp_data_q.size() || viol_cnt != 0
                || wr_addr_q.size() != (skip ? 0 : len) || post_busy != 0) begin
                failures++;
                $display("FAIL rand[%0d] len=%0d reps=%0d skip=%0d: got beats %0d bad %0d writes %0d viol %0d timeout %0d required beats %0d",
                         it, len, reps, skip, beat_data_q.size(), bad, wr_addr_q.size(), viol_cnt, timed_out, exp_data_q.size());
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1'b1; skip_load = 1'b1; cfg_len = 7'd8; cfg_reps = 8'd3; in_valid = 1'b0; w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (!(busy && w_valid)) begin failures++; $display("FAIL mid_stream_active: got busy %0d w_valid %0d required 1 1", busy, w_valid); end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, spad_wr, spad_rd, spad_addr, spad_wdata, w_valid, w_data, w_last, busy, done, cfg_err} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h required 0", {in_ready, spad_wr, spad_rd, spad_addr, spad_wdata, w_valid, w_data, w_last, busy, done, cfg_err});
        end
        @(negedge clk);
        in_valid = 1'b0;
        run_cmd(8, 1, 1'b1, 100, 100, -1, 1'b0);
        build_expect(8, 1);
        checks++;
        if (beat_data_q != exp_data_q || timed_out) begin
            failures++; $display("FAIL mid_reset_restart: got %0d beats timeout %0d, required the 8 stored weights", beat_data_q.size(), timed_out);
        end
    endtask

    initial begin
        test_reset();
        test_load_stream();
        test_backpressure();
        test_cfg_err();
        test_reuse();
        test_full_depth();
        test_start_ignored();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
